// File: rtl/sat_compare_mux_pkg.sv
// ---------------------------------------------------------------------------
// sat_cmp_pkg
// Shared definitions for the saturation A/B comparison stage.
// Contents:
//   mode_e         - output selection modes (raw / enhanced / fixed / sweep)
//   sweep_state_e  - divider sweep FSM encoding
//   RGB565 field widths, pixel position width, signed divider width
// ---------------------------------------------------------------------------
package sat_cmp_pkg;

  // RGB565 field widths; the packed pixel is the sum of the three fields.
  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;
  localparam int RGB_W   = RGB_R_W + RGB_G_W + RGB_B_W;

  // Column / divider width and the one-bit-wider signed width used while
  // stepping the divider, so both underflow and overflow stay visible.
  localparam int POS_W = 11;
  localparam int DIV_W = POS_W + 1;

  typedef enum logic [1:0] {
    MODE_RAW   = 2'd0,
    MODE_DST   = 2'd1,
    MODE_SPLIT = 2'd2,
    MODE_SWEEP = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    SWEEP_HOLD  = 2'd0,
    SWEEP_RIGHT = 2'd1,
    SWEEP_LEFT  = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/sat_compare_mux_if.sv
// ---------------------------------------------------------------------------
// sat_compare_mux_if
// Pixel bus of the comparison stage: the aligned raw/enhanced input streams
// with their timing, the frame configuration pins, and the output stream.
// Modports:
//   master - source side: drives raw_data, dst_data, in_de, in_vs, mode,
//            split_x; receives out_data, out_de, out_vs
//   slave  - comparison stage side (the reverse directions)
// ---------------------------------------------------------------------------
interface sat_compare_mux_if;
  import sat_cmp_pkg::*;

  logic [RGB_W-1:0] raw_data;
  logic [RGB_W-1:0] dst_data;
  logic             in_de;
  logic             in_vs;
  logic [1:0]       mode;
  logic [POS_W-1:0] split_x;
  logic [RGB_W-1:0] out_data;
  logic             out_de;
  logic             out_vs;

  modport master (
    output raw_data, dst_data, in_de, in_vs, mode, split_x,
    input  out_data, out_de, out_vs
  );

  modport slave (
    input  raw_data, dst_data, in_de, in_vs, mode, split_x,
    output out_data, out_de, out_vs
  );

endinterface

// File: rtl/sat_compare_mux_pos.sv
// ---------------------------------------------------------------------------
// pixel_pos_counter
// Tracks the column/line position of the pixel currently presented on a
// DE/VS video stream. Reusable by any overlay stage that needs coordinates.
// Ports:
//   clk, rst_n - pixel clock, asynchronous active-low reset
//   de, vs     - data enable and vertical sync of the incoming stream
//   x          - column of the pixel on the bus this cycle, saturating
//   y          - completed-line count in the current frame, saturating
//   vs_rise    - combinational pulse on the first cycle vs is high
// ---------------------------------------------------------------------------
module pixel_pos_counter
  import sat_cmp_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int X_W      = POS_W,
  parameter int Y_W      = $clog2(V_ACTIVE)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           de,
  input  logic           vs,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           vs_rise
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

  logic de_q;
  logic vs_q;
  logic de_fall;

  assign de_fall = de_q & ~de;
  assign vs_rise = vs & ~vs_q;

  // x holds the column of the pixel on the bus now; it parks at the last
  // column for over-long lines and is cleared during blanking so the next
  // line starts at 0. y counts line ends; a frame start clears it and wins
  // over a coincident line end. vs_q comes out of reset high so a vs that is
  // already high when reset lifts is not mistaken for a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      de_q <= 1'b0;
      vs_q <= 1'b1;
    end else begin
      de_q <= de;
      vs_q <= vs;

      if (de) begin
        if (x != X_LAST) begin
          x <= x + 1'b1;
        end
      end else begin
        x <= '0;
      end

      if (vs_rise) begin
        y <= '0;
      end else if (de_fall && (y != Y_LAST)) begin
        y <= y + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sat_compare_mux.sv
// ---------------------------------------------------------------------------
// sat_compare_mux
// A/B comparison stage for the saturation enhancement path. Selects per frame
// between the raw stream, the enhanced stream, or a split screen (raw left of
// a divider column, enhanced right, marker colour on the divider). In sweep
// mode the divider bounces across the screen by SWEEP_STEP each frame.
// Ports:
//   clk   - pixel clock
//   rst_n - asynchronous active-low reset
//   bus   - sat_compare_mux_if.slave: raw_data, dst_data, in_de, in_vs,
//           mode, split_x in; out_data, out_de, out_vs out (1 clk latency)
// ---------------------------------------------------------------------------
module sat_compare_mux
  import sat_cmp_pkg::*;
#(
  parameter int               H_ACTIVE   = 1280,
  parameter int               V_ACTIVE   = 720,
  parameter logic [RGB_W-1:0] LINE_COLOR = 16'hFFFF,
  parameter int               SWEEP_STEP = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sat_compare_mux_if.slave        bus
);

  localparam int Y_W = $clog2(V_ACTIVE);

  localparam logic [POS_W-1:0]        X_LAST   = POS_W'(H_ACTIVE - 1);
  localparam logic [POS_W-1:0]        X_MID    = POS_W'(H_ACTIVE / 2);
  localparam logic signed [DIV_W-1:0] DIV_LAST = DIV_W'(H_ACTIVE - 1);
  localparam logic signed [DIV_W-1:0] DIV_STEP = DIV_W'(SWEEP_STEP);
  localparam logic signed [DIV_W-1:0] DIV_ZERO = '0;

  logic [POS_W-1:0]        x;
  logic [Y_W-1:0]          line_y;
  logic                    vs_rise;

  mode_e                   shadow_mode;
  mode_e                   next_mode;
  sweep_state_e            state;
  sweep_state_e            next_state;
  logic [POS_W-1:0]        divider;
  logic [POS_W-1:0]        next_divider;
  logic [POS_W-1:0]        split_clamped;
  logic signed [DIV_W-1:0] div_ext;
  logic signed [DIV_W-1:0] div_up;
  logic signed [DIV_W-1:0] div_dn;
  logic [RGB_W-1:0]        pix_next;

  pixel_pos_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .X_W      (POS_W),
    .Y_W      (Y_W)
  ) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .de      (bus.in_de),
    .vs      (bus.in_vs),
    .x       (x),
    .y       (line_y),
    .vs_rise (vs_rise)
  );

  // A divider beyond the visible area would never draw the marker, so the
  // requested column is pulled back onto the last active pixel.
  assign split_clamped = (bus.split_x > X_LAST) ? X_LAST : bus.split_x;

  // Shadow configuration and sweep state. Everything here only moves on a
  // frame start, so the picture never tears part-way down the screen. Reset
  // leaves the stage in raw passthrough with the divider mid-screen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SWEEP_HOLD;
      shadow_mode <= MODE_RAW;
      divider     <= X_MID;
    end else begin
      state       <= next_state;
      shadow_mode <= next_mode;
      divider     <= next_divider;
    end
  end

  // Next-state logic for the sweep. The divider is widened to a signed value
  // before stepping so a step past either edge shows up as >= last column or
  // <= 0, and is then clamped onto the edge while the direction flips.
  always_comb begin
    next_state   = state;
    next_mode    = shadow_mode;
    next_divider = divider;
    div_ext      = $signed({1'b0, divider});
    div_up       = div_ext + DIV_STEP;
    div_dn       = div_ext - DIV_STEP;

    if (vs_rise) begin
      next_mode = mode_e'(bus.mode);
      if (next_mode != MODE_SWEEP) begin
        next_state   = SWEEP_HOLD;
        next_divider = split_clamped;
      end else begin
        case (state)
          SWEEP_HOLD: begin
            next_divider = split_clamped;
            next_state   = SWEEP_RIGHT;
          end
          SWEEP_RIGHT: begin
            if (div_up >= DIV_LAST) begin
              next_divider = X_LAST;
              next_state   = SWEEP_LEFT;
            end else begin
              next_divider = div_up[POS_W-1:0];
            end
          end
          SWEEP_LEFT: begin
            if (div_dn <= DIV_ZERO) begin
              next_divider = '0;
              next_state   = SWEEP_RIGHT;
            end else begin
              next_divider = div_dn[POS_W-1:0];
            end
          end
          default: begin
            next_divider = split_clamped;
            next_state   = SWEEP_HOLD;
          end
        endcase
      end
    end
  end

  // Pixel selection. Blanking is forced to black; in the split modes the
  // divider column itself carries the marker colour, raw sits to its left
  // and enhanced to its right.
  always_comb begin
    pix_next = '0;
    if (bus.in_de) begin
      case (shadow_mode)
        MODE_RAW: pix_next = bus.raw_data;
        MODE_DST: pix_next = bus.dst_data;
        default: begin
          if (x == divider) begin
            pix_next = LINE_COLOR;
          end else if (x < divider) begin
            pix_next = bus.raw_data;
          end else begin
            pix_next = bus.dst_data;
          end
        end
      endcase
    end
  end

  // Output register: data, DE and VS all pass through exactly one stage so
  // the timing stays aligned with the selected pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data <= '0;
      bus.out_de   <= 1'b0;
      bus.out_vs   <= 1'b0;
    end else begin
      bus.out_data <= pix_next;
      bus.out_de   <= bus.in_de;
      bus.out_vs   <= bus.in_vs;
    end
  end

endmodule

// File: tb/tb_sat_compare_mux.sv
// ---------------------------------------------------------------------------
// tb_sat_compare_mux
// Self-checking bench for sat_compare_mux. Every driven cycle pushes its
// expected output onto a queue; a monitor pops and compares one entry after
// each rising edge. Frame configurations with their expected dividers come
// from a table; mid-frame config change, over-long lines, mid-frame reset
// and the full sweep back to column 0 are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_sat_compare_mux;
  import sat_cmp_pkg::*;

  localparam int H = 1280;
  localparam logic [15:0] LINE_C = 16'hFFFF;

  typedef struct packed {
    logic        de;
    logic        vs;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    int mode;
    int split;
    int div;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drive_rst = 1'b0;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_mode = 0;
  int   exp_div = 0;
  vec_t tbl[11];

  always #5 clk = ~clk;

  sat_compare_mux_if bus ();

  sat_compare_mux #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (720),
    .LINE_COLOR (LINE_C),
    .SWEEP_STEP (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected pixel from the column the bench itself is driving.
  function automatic logic [15:0] expected_pixel(input logic de, input logic [15:0] raw,
                                                 input logic [15:0] dst, input int col);
    int cc;
    cc = (col > H - 1) ? H - 1 : col;
    if (!de) return 16'h0000;
    if (exp_mode == 0) return raw;
    if (exp_mode == 1) return dst;
    if (cc == exp_div) return LINE_C;
    if (cc < exp_div) return raw;
    return dst;
  endfunction

  task automatic applyStimulus(input logic de, input logic vs, input int col);
    exp_t        e;
    logic [15:0] raw;
    logic [15:0] dst;
    raw = 16'($urandom);
    dst = 16'($urandom);
    @(negedge clk);
    rst_n      = drive_rst;
    bus.in_de  = de;
    bus.in_vs  = vs;
    bus.raw_data = raw;
    bus.dst_data = dst;
    if (!rst_n) begin
      e = '0;
    end else begin
      e.de   = de;
      e.vs   = vs;
      e.data = expected_pixel(de, raw, dst, col);
    end
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    total++;
    if (bus.out_de !== e.de || bus.out_vs !== e.vs || bus.out_data !== e.data) begin
      bad++;
      $display("[TB] FAIL pixel#%0d got de=%b vs=%b data=%h want de=%b vs=%b data=%h (mode=%0d div=%0d)",
               total, bus.out_de, bus.out_vs, bus.out_data, e.de, e.vs, e.data, exp_mode, exp_div);
    end
  endtask

  task automatic start_frame(input int m, input int s);
    bus.mode    = 2'(m);
    bus.split_x = 11'(s);
    repeat (2) applyStimulus(1'b0, 1'b1, 0);
    repeat (2) applyStimulus(1'b0, 1'b0, 0);
  endtask

  // One active line; when rst_at >= 0 reset is held low for 3 cycles
  // starting at that column, after which the stage is in raw passthrough.
  task automatic send_line(input int len, input int rst_at);
    for (int c = 0; c < len; c++) begin
      if (c == rst_at) drive_rst = 1'b0;
      if (rst_at >= 0 && c == rst_at + 3) begin
        drive_rst = 1'b1;
        exp_mode  = 0;
      end
      applyStimulus(1'b1, 1'b0, c);
    end
    repeat (4) applyStimulus(1'b0, 1'b0, 0);
  endtask

  // Monitor: one expected entry per driven cycle, checked after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    tbl[0]  = '{0, 100, 0};
    tbl[1]  = '{1, 100, 0};
    tbl[2]  = '{2, 100, 100};
    tbl[3]  = '{2, 2047, 1279};
    tbl[4]  = '{2, 0, 0};
    tbl[5]  = '{3, 1270, 1270};
    tbl[6]  = '{3, 0, 1274};
    tbl[7]  = '{3, 0, 1278};
    tbl[8]  = '{3, 0, 1279};
    tbl[9]  = '{3, 5, 1275};
    tbl[10] = '{2, 100, 100};

    bus.in_de = 1'b0;
    bus.in_vs = 1'b0;
    bus.raw_data = '0;
    bus.dst_data = '0;
    bus.mode = '0;
    bus.split_x = '0;

    // Reset: outputs must hold zero.
    drive_rst = 1'b0;
    repeat (4) applyStimulus(1'b0, 1'b0, 0);
    drive_rst = 1'b1;
    repeat (2) applyStimulus(1'b0, 1'b0, 0);

    // Table-driven frames: fixed modes, clamp, and the right-hand sweep bounce.
    for (int i = 0; i < 11; i++) begin
      exp_mode = tbl[i].mode;
      exp_div  = tbl[i].div;
      start_frame(tbl[i].mode, tbl[i].split);
      repeat (2) send_line(H, -1);
    end

    // split_x changed mid-frame only shows up from the next frame.
    $display("[TB] mid-frame split change");
    exp_mode = 2;
    exp_div  = 100;
    start_frame(2, 100);
    send_line(H, -1);
    bus.split_x = 11'd200;
    send_line(H, -1);
    exp_div = 200;
    start_frame(2, 200);
    send_line(H, -1);

    // Over-long lines: columns past the edge behave as the last column.
    $display("[TB] over-long lines");
    exp_div = 1000;
    start_frame(2, 1000);
    repeat (3) send_line(1300, -1);
    total++;
    if (int'(dut.line_y) != 3) begin
      bad++;
      $display("[TB] FAIL line_count got=%0d want=3", int'(dut.line_y));
    end

    // Reset in the middle of a split frame.
    $display("[TB] mid-frame reset");
    exp_div = 100;
    start_frame(2, 100);
    send_line(H, -1);
    send_line(H, 500);
    send_line(H, -1);
    exp_mode = 2;
    exp_div  = 300;
    start_frame(2, 300);
    send_line(H, -1);

    // Full sweep: up to the right edge, then down to 0 and back right.
    $display("[TB] sweep to left edge");
    exp_mode = 3;
    exp_div  = 1278;
    start_frame(3, 1278);
    send_line(8, -1);
    for (int f = 1; f <= 322; f++) begin
      if (f == 1)        exp_div = 1279;
      else if (f <= 320) exp_div = 1279 - 4 * (f - 1);
      else if (f == 321) exp_div = 0;
      else               exp_div = 4;
      start_frame(3, 0);
      send_line(8, -1);
    end

    repeat (3) applyStimulus(1'b0, 1'b0, 0);
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
